// File: rtl/serial_rx_pkg.sv
// Shared types and frame constants for the serial receiver.
// Contents: FSM state enum, start/stop bit levels, counter width helper.
// Optional feature macro: SERIAL_RX_PARITY_EN enables the odd-parity check.
package serial_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Bit counter width able to hold 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Receive FIFO for serial_rx: wrapped pointers with an extra bit for full/empty.
// Ports:
//   clk, rst       system clock, async active-high reset
//   i_wr           write request (a received good frame)
//   i_wr_data      frame payload
//   o_rd_data      head entry, 0 while empty
//   o_valid        FIFO non-empty
//   i_ready        consumer accepts head
//   o_overflow     one-cycle pulse when a write is dropped on a full FIFO
module serial_rx_fifo #(
   parameter int unsigned DATA_LEN   = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_wr,
   input  logic [DATA_LEN-1:0] i_wr_data,
   output logic [DATA_LEN-1:0] o_rd_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [DATA_LEN-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic                r_overflow;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && i_ready;
   // A write into a full FIFO is fine when the head leaves in the same cycle.
   assign w_push  = i_wr && (!w_full || w_pop);

   // Pointer and overflow update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         r_overflow <= i_wr && !w_push;
      end
   end

   // Storage; contents are never visible while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   assign o_valid    = !w_empty;
   assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_overflow = r_overflow;

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: synchronizes an external serial clock/data pair,
// deframes start/data(LSB first)/parity/stop on serial-clock falling edges
// and queues good frames in a FIFO.
// Ports:
//   clk, rst              system clock, async active-high reset
//   ser_clk, ser_data     external serial clock and data (asynchronous)
//   out_data, out_valid   FIFO head and non-empty flag
//   out_ready             consumer accepts head
//   overflow              one-cycle pulse, good frame dropped on full FIFO
//   frame_err             one-cycle pulse, bad stop or parity
// Optional feature macro: SERIAL_RX_PARITY_EN (odd parity checked when defined,
// otherwise the parity bit is sampled and ignored). DATA_LEN must be >= 2.
module serial_rx
   import serial_rx_pkg::*;
#(
   parameter int unsigned DATA_LEN   = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ser_clk,
   input  logic                ser_data,
   output logic [DATA_LEN-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overflow,
   output logic                frame_err
);

   localparam int unsigned CNT_W = cnt_width(DATA_LEN);

   logic                r_sclk_s1, r_sclk_s2, r_sclk_prev;
   logic                r_sdat_s1, r_sdat_s2;
   logic                w_fall;
   logic                w_bit;

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [DATA_LEN-1:0] r_shift, w_shift_nxt;
   logic                r_good, w_good_nxt;
   logic                r_bad, w_bad_nxt;
   logic                w_par_ok;

   // Two-flop synchronizers plus previous-value flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_s1   <= 1'b1;
         r_sclk_s2   <= 1'b1;
         r_sclk_prev <= 1'b1;
         r_sdat_s1   <= 1'b1;
         r_sdat_s2   <= 1'b1;
      end else begin
         r_sclk_s1   <= ser_clk;
         r_sclk_s2   <= r_sclk_s1;
         r_sclk_prev <= r_sclk_s2;
         r_sdat_s1   <= ser_data;
         r_sdat_s2   <= r_sdat_s1;
      end
   end

   assign w_fall = !r_sclk_s2 && r_sclk_prev;
   assign w_bit  = r_sdat_s2;

`ifdef SERIAL_RX_PARITY_EN
   logic r_parity, w_parity_nxt;

   // Odd parity: data bits plus parity bit carry an odd number of ones.
   assign w_par_ok = (^r_shift) ^ r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_parity <= 1'b0;
      else     r_parity <= w_parity_nxt;
   end

   always_comb begin
      w_parity_nxt = r_parity;
      if (w_fall && (r_state == ST_PARITY)) w_parity_nxt = w_bit;
   end
`else
   assign w_par_ok = 1'b1;
`endif

   // Deframer state register; good/bad strobes land one cycle after the stop sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_good  <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_good  <= w_good_nxt;
         r_bad   <= w_bad_nxt;
      end
   end

   // Next-state logic; advances only on a detected serial-clock fall.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_good_nxt  = 1'b0;
      w_bad_nxt   = 1'b0;
      if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (w_bit == START_BIT) begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = '0;
               end
            end
            ST_DATA: begin
               w_shift_nxt = {w_bit, r_shift[DATA_LEN-1:1]};
               if (r_cnt == CNT_W'(DATA_LEN - 1)) w_state_nxt = ST_PARITY;
               else                               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_PARITY: begin
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               if ((w_bit == STOP_BIT) && w_par_ok) w_good_nxt = 1'b1;
               else                                 w_bad_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign frame_err = r_bad;

   serial_rx_fifo #(
      .DATA_LEN   (DATA_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (r_good),
      .i_wr_data  (r_shift),
      .o_rd_data  (out_data),
      .o_valid    (out_valid),
      .i_ready    (out_ready),
      .o_overflow (overflow)
   );

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: frames are bit-banged on ser_clk/ser_data and
// outputs are sampled on the falling edge of clk.
module tb_serial_rx;

   logic       clk;
   logic       rst;
   logic       ser_clk;
   logic       ser_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overflow;
   logic       frame_err;

   int n_cmp;
   int n_bad;
   int err_hi;
   int ovf_hi;
   logic [7:0] popped[$];

   serial_rx #(.DATA_LEN(8), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_clk   (ser_clk),
      .ser_data  (ser_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe pulses and accepted bytes away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_hi++;
         if (overflow)  ovf_hi++;
         if (out_valid && out_ready) popped.push_back(out_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic send_bit(input logic b);
      ser_data = b;
      ser_clk  = 1'b1;
      tick(6);
      ser_clk  = 1'b0;
      tick(6);
   endtask

   task automatic send_head(input logic [7:0] d, input logic p);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_head(d, p);
      send_bit(s);
      ser_clk = 1'b1;
      tick(6);
   endtask

   task automatic clear_obs();
      err_hi = 0;
      ovf_hi = 0;
      popped.delete();
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; ser_clk = 1'b1; ser_data = 1'b1; out_ready = 1'b0;
      clear_obs();
      tick(3);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_ovf",   32'(overflow),  32'd0);
      chk("rst_ferr",  32'(frame_err), 32'd0);
      rst = 1'b0;
      tick(4);

      // Good frame 0x1C, parity 0 is correct odd parity.
      out_ready = 1'b1;
      clear_obs();
      send_frame(8'h1C, 1'b0, 1'b1);
      tick(10);
      chk("f1c_cnt",  32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("f1c_data", 32'(popped[0]), 32'h1C);
      chk("f1c_ferr", 32'(err_hi), 32'd0);
      chk("f1c_ovf",  32'(ovf_hi), 32'd0);
      chk("f1c_idle_data", 32'(out_data), 32'd0);

      // 0xA5 with wrong parity.
      clear_obs();
      send_frame(8'hA5, 1'b0, 1'b1);
      tick(10);
`ifdef SERIAL_RX_PARITY_EN
      chk("fa5_ferr", 32'(err_hi), 32'd1);
      chk("fa5_cnt",  32'(popped.size()), 32'd0);
`else
      chk("fa5_ferr", 32'(err_hi), 32'd0);
      chk("fa5_cnt",  32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("fa5_data", 32'(popped[0]), 32'hA5);
`endif
      chk("fa5_valid", 32'(out_valid), 32'd0);

      // 0x3C with bad stop bit.
      clear_obs();
      send_frame(8'h3C, odd_par(8'h3C), 1'b0);
      tick(10);
      chk("f3c_ferr",  32'(err_hi), 32'd1);
      chk("f3c_cnt",   32'(popped.size()), 32'd0);
      chk("f3c_valid", 32'(out_valid), 32'd0);

      // Fill with 0x01..0x08, the 9th overflows.
      out_ready = 1'b0;
      clear_obs();
      for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
      tick(10);
      chk("ovf_pulse", 32'(ovf_hi), 32'd1);
      chk("ovf_ferr",  32'(err_hi), 32'd0);
      chk("ovf_valid", 32'(out_valid), 32'd1);
      chk("ovf_head",  32'(out_data), 32'h01);
      out_ready = 1'b1;
      tick(12);
      chk("ovf_cnt", 32'(popped.size()), 32'd8);
      for (int i = 0; i < popped.size(); i++) chk("ovf_order", 32'(popped[i]), 32'(i + 1));
      chk("ovf_empty", 32'(out_valid), 32'd0);

      // Reset after four data bits of 0xFF, then a clean 0x55.
      clear_obs();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ser_clk = 1'b1;
      rst = 1'b1;
      tick(3);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ferr",  32'(frame_err), 32'd0);
      rst = 1'b0;
      tick(4);
      send_frame(8'h55, odd_par(8'h55), 1'b1);
      tick(10);
      chk("r55_cnt",  32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("r55_data", 32'(popped[0]), 32'h55);
      chk("r55_ferr", 32'(err_hi), 32'd0);

      // Full FIFO, 9th write coincides with a single pop.
      out_ready = 1'b0;
      clear_obs();
      for (int i = 1; i <= 8; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
      send_head(8'h09, odd_par(8'h09));
      ser_data = 1'b1;
      ser_clk  = 1'b1;
      tick(6);
      ser_clk  = 1'b0;
      tick(3);           // stop bit sampled at this edge; write lands on the next
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(3);
      ser_clk = 1'b1;
      tick(6);
      chk("coin_ovf", 32'(ovf_hi), 32'd0);
      chk("coin_pop1", 32'(popped.size()), 32'd1);
      chk("coin_head", 32'(out_data), 32'h02);
      out_ready = 1'b1;
      tick(12);
      chk("coin_cnt", 32'(popped.size()), 32'd9);
      for (int i = 0; i < popped.size(); i++) chk("coin_order", 32'(popped[i]), 32'(i + 1));
      chk("coin_empty", 32'(out_valid), 32'd0);
      chk("coin_ferr",  32'(err_hi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
